// File: rtl/dbus_arbiter_if.sv
// Signal bundle for the two-master data bus arbiter: requester ports 0/1,
// the shared slave port, and the grant/busy observation outputs.
interface dbus_arbiter_if;
   logic        m0_rd_en, m1_rd_en;
   logic        m0_wr_en, m1_wr_en;
   logic [31:0] m0_addr, m1_addr;
   logic [31:0] m0_wr_data, m1_wr_data;
   logic [3:0]  m0_wr_strobe, m1_wr_strobe;
   logic [31:0] m0_rd_data, m1_rd_data;
   logic        m0_wait, m1_wait;
   logic        m0_err, m1_err;
   logic        s_rd_en, s_wr_en;
   logic [31:0] s_addr;
   logic [31:0] s_wr_data;
   logic [3:0]  s_wr_strobe;
   logic [31:0] s_rd_data;
   logic        s_wait;
   logic        s_err;
   logic [1:0]  grant;
   logic        busy;

   // Arbiter view: it is the slave of both requesters and drives the shared bus.
   modport slave (
      input  m0_rd_en, m1_rd_en, m0_wr_en, m1_wr_en, m0_addr, m1_addr,
             m0_wr_data, m1_wr_data, m0_wr_strobe, m1_wr_strobe,
             s_rd_data, s_wait, s_err,
      output m0_rd_data, m1_rd_data, m0_wait, m1_wait, m0_err, m1_err,
             s_rd_en, s_wr_en, s_addr, s_wr_data, s_wr_strobe, grant, busy
   );

   // Environment view: requesters plus the downstream slave.
   modport master (
      output m0_rd_en, m1_rd_en, m0_wr_en, m1_wr_en, m0_addr, m1_addr,
             m0_wr_data, m1_wr_data, m0_wr_strobe, m1_wr_strobe,
             s_rd_data, s_wait, s_err,
      input  m0_rd_data, m1_rd_data, m0_wait, m1_wait, m0_err, m1_err,
             s_rd_en, s_wr_en, s_addr, s_wr_data, s_wr_strobe, grant, busy
   );
endinterface

// File: rtl/dbus_arbiter.sv
// Zero-latency round-robin arbiter sharing the core DBus between the LSU (port 0)
// and a secondary master (port 1). Optional wait timeout: DBUS_ARB_TIMEOUT_EN.
module dbus_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic           clk,
   input logic           rst,
   dbus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_e;

   state_e state_q;
   logic   last_q;

   logic req0, req1;
   logic own_v, own;
   logic done, to;
   logic        sel_rd, sel_wr;
   logic [31:0] sel_addr, sel_wdata;
   logic [3:0]  sel_strb;

   assign req0 = bus.m0_rd_en | bus.m0_wr_en;
   assign req1 = bus.m1_rd_en | bus.m1_wr_en;
   assign done = ~bus.s_wait | bus.s_err;

   // Owner: the held port while it keeps requesting, else the IDLE winner.
   always_comb begin
      own   = 1'b0;
      own_v = 1'b0;
      case (state_q)
         HOLD0: begin own = 1'b0; own_v = req0; end
         HOLD1: begin own = 1'b1; own_v = req1; end
         default: begin
            own_v = req0 | req1;
            if (req0 & req1) own = ~last_q;
            else             own = req1;
         end
      endcase
   end

`ifdef DBUS_ARB_TIMEOUT_EN
   localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WCW-1:0] wcnt_q;

   assign to = (state_q != IDLE) & own_v & bus.s_wait & ~bus.s_err &
               (wcnt_q == WCW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt_q <= '0;
      end else if (state_q == IDLE) begin
         wcnt_q <= (own_v & ~done) ? WCW'(1) : '0;
      end else if (~own_v | done | to) begin
         wcnt_q <= '0;
      end else if (wcnt_q != '1) begin
         wcnt_q <= wcnt_q + WCW'(1);
      end
   end
`else
   assign to = 1'b0;
`endif

   assign sel_rd    = own ? bus.m1_rd_en     : bus.m0_rd_en;
   assign sel_wr    = own ? bus.m1_wr_en     : bus.m0_wr_en;
   assign sel_addr  = own ? bus.m1_addr      : bus.m0_addr;
   assign sel_wdata = own ? bus.m1_wr_data   : bus.m0_wr_data;
   assign sel_strb  = own ? bus.m1_wr_strobe : bus.m0_wr_strobe;

   assign bus.m0_rd_data = bus.s_rd_data;
   assign bus.m1_rd_data = bus.s_rd_data;
   assign bus.busy       = (state_q != IDLE) & ~rst;

   // Reset overrides everything so the slave sees enables fall immediately.
   always_comb begin
      bus.s_rd_en     = 1'b0;
      bus.s_wr_en     = 1'b0;
      bus.s_addr      = '0;
      bus.s_wr_data   = '0;
      bus.s_wr_strobe = '0;
      bus.grant       = 2'b00;
      bus.m0_wait     = req0;
      bus.m1_wait     = req1;
      bus.m0_err      = 1'b0;
      bus.m1_err      = 1'b0;
      if (rst) begin
         bus.m0_wait = 1'b1;
         bus.m1_wait = 1'b1;
      end else if (own_v) begin
         bus.s_rd_en     = sel_rd & ~to;
         bus.s_wr_en     = sel_wr & ~to;
         bus.s_addr      = sel_addr;
         bus.s_wr_data   = sel_wdata;
         bus.s_wr_strobe = sel_strb;
         bus.grant       = own ? 2'b10 : 2'b01;
         if (own) begin
            bus.m1_wait = ~to & bus.s_wait & ~bus.s_err;
            bus.m1_err  = to | bus.s_err;
         end else begin
            bus.m0_wait = ~to & bus.s_wait & ~bus.s_err;
            bus.m0_err  = to | bus.s_err;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (own_v) begin
                  if (done) last_q  <= own;
                  else      state_q <= own ? HOLD1 : HOLD0;
               end
            end
            default: begin
               // A withdrawn request returns to IDLE without crediting the port.
               if (!own_v) begin
                  state_q <= IDLE;
               end else if (done | to) begin
                  state_q <= IDLE;
                  last_q  <= own;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: per-cycle comparison against a transaction-level
// model plus literal spot checks. Define DBUS_ARB_TIMEOUT_EN to cover the timeout path.
module tb_dbus_arbiter;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dbus_arbiter_if bus();
   dbus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic        rd[2], wr[2];
   logic [31:0] ad[2], wd[2];
   logic [3:0]  st[2];
   logic [31:0] srd;
   logic        sw, se;

   assign bus.m0_rd_en = rd[0];  assign bus.m1_rd_en = rd[1];
   assign bus.m0_wr_en = wr[0];  assign bus.m1_wr_en = wr[1];
   assign bus.m0_addr  = ad[0];  assign bus.m1_addr  = ad[1];
   assign bus.m0_wr_data = wd[0]; assign bus.m1_wr_data = wd[1];
   assign bus.m0_wr_strobe = st[0]; assign bus.m1_wr_strobe = st[1];
   assign bus.s_rd_data = srd;
   assign bus.s_wait    = sw;
   assign bus.s_err     = se;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model state: holder = -1 when nobody holds the bus, else the holding port.
   int holder = -1;
   int lastp  = 1;
   int wcyc   = 0;

   always @(negedge clk) begin : cmp
      int own, o;
      bit tmo, r[2];
      logic aw[2], ae[2];
      logic [31:0] er[2];
      aw[0] = bus.m0_wait; aw[1] = bus.m1_wait;
      ae[0] = bus.m0_err;  ae[1] = bus.m1_err;
      er[0] = bus.m0_rd_data; er[1] = bus.m1_rd_data;
      r[0] = rd[0] | wr[0];
      r[1] = rd[1] | wr[1];
      if (rst) begin
         chk("rst s_rd_en", {31'b0, bus.s_rd_en}, 0);
         chk("rst s_wr_en", {31'b0, bus.s_wr_en}, 0);
         chk("rst s_wr_strobe", {28'b0, bus.s_wr_strobe}, 0);
         chk("rst grant", {30'b0, bus.grant}, 0);
         chk("rst busy", {31'b0, bus.busy}, 0);
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("rst m%0d_wait", p), {31'b0, aw[p]}, 1);
            chk($sformatf("rst m%0d_err", p), {31'b0, ae[p]}, 0);
         end
         holder = -1; lastp = 1; wcyc = 0;
      end else begin
         if (holder < 0) begin
            if (r[0] && r[1]) own = 1 - lastp;
            else if (r[0])    own = 0;
            else if (r[1])    own = 1;
            else              own = -1;
         end else begin
            own = r[holder] ? holder : -1;
         end
         o = (own < 0) ? 0 : own;
         tmo = 1'b0;
`ifdef DBUS_ARB_TIMEOUT_EN
         tmo = (holder >= 0) && (own >= 0) && (wcyc == TO) && sw && !se;
`endif
         chk("s_rd_en", {31'b0, bus.s_rd_en}, (own >= 0 && !tmo) ? {31'b0, rd[o]} : 0);
         chk("s_wr_en", {31'b0, bus.s_wr_en}, (own >= 0 && !tmo) ? {31'b0, wr[o]} : 0);
         chk("s_addr", bus.s_addr, (own >= 0) ? ad[o] : 0);
         chk("s_wr_data", bus.s_wr_data, (own >= 0) ? wd[o] : 0);
         chk("s_wr_strobe", {28'b0, bus.s_wr_strobe}, (own >= 0) ? {28'b0, st[o]} : 0);
         chk("grant", {30'b0, bus.grant}, (own >= 0) ? (32'd1 << own) : 0);
         chk("busy", {31'b0, bus.busy}, (holder >= 0) ? 1 : 0);
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("m%0d_rd_data", p), er[p], srd);
            if (p == own) begin
               chk($sformatf("m%0d_wait", p), {31'b0, aw[p]}, (!tmo && sw && !se) ? 1 : 0);
               chk($sformatf("m%0d_err", p), {31'b0, ae[p]}, (tmo || se) ? 1 : 0);
            end else begin
               chk($sformatf("m%0d_wait", p), {31'b0, aw[p]}, {31'b0, r[p]});
               chk($sformatf("m%0d_err", p), {31'b0, ae[p]}, 0);
            end
         end
         if (own < 0) begin
            holder = -1; wcyc = 0;
         end else if (tmo || !sw || se) begin
            lastp = own; holder = -1; wcyc = 0;
         end else if (holder < 0) begin
            holder = own; wcyc = 1;
         end else begin
            wcyc++;
         end
      end
   end

   task automatic idle_in();
      for (int p = 0; p < 2; p++) begin
         rd[p] = 1'b0; wr[p] = 1'b0; ad[p] = '0; wd[p] = '0; st[p] = '0;
      end
      sw = 1'b0; se = 1'b0;
   endtask

   task automatic go();
      @(posedge clk); #1;
   endtask

   initial begin
      idle_in(); srd = '0;
      rd[0] = 1'b1; rd[1] = 1'b1;
      @(negedge clk);
      chk("L reset grant", {30'b0, bus.grant}, 0);
      chk("L reset m0_wait", {31'b0, bus.m0_wait}, 1);
      chk("L reset s_rd_en", {31'b0, bus.s_rd_en}, 0);

      // Uncontended LSU load completes in the same cycle.
      go(); rst = 1'b0; idle_in();
      rd[0] = 1'b1; ad[0] = 32'h100; srd = 32'hDEADBEEF;
      @(negedge clk);
      chk("L lw s_rd_en", {31'b0, bus.s_rd_en}, 1);
      chk("L lw s_addr", bus.s_addr, 32'h100);
      chk("L lw m0_rd_data", bus.m0_rd_data, 32'hDEADBEEF);
      chk("L lw m0_wait", {31'b0, bus.m0_wait}, 0);
      chk("L lw grant", {30'b0, bus.grant}, 1);
      go(); idle_in();
      @(negedge clk);
      chk("L lw busy after", {31'b0, bus.busy}, 0);

      go(); rst = 1'b1;
      go(); rst = 1'b0;

      // Contention alternates starting with port 0.
      for (int i = 0; i < 5; i++) begin
         go(); idle_in();
         rd[0] = 1'b1; rd[1] = 1'b1; ad[0] = 32'h10 + i; ad[1] = 32'h20 + i;
         @(negedge clk);
         chk($sformatf("L rr grant %0d", i), {30'b0, bus.grant}, (i % 2 == 0) ? 1 : 2);
      end

      // Port 1 store stretched by three wait cycles while port 0 waits.
      go(); idle_in();
      rd[0] = 1'b1; ad[0] = 32'h300;
      wr[1] = 1'b1; ad[1] = 32'h200; wd[1] = 32'h12345678; st[1] = 4'hF; sw = 1'b1;
      @(negedge clk);
      chk("L sw grant", {30'b0, bus.grant}, 2);
      chk("L sw s_addr", bus.s_addr, 32'h200);
      chk("L sw busy0", {31'b0, bus.busy}, 0);
      chk("L sw m0_wait0", {31'b0, bus.m0_wait}, 1);
      for (int k = 1; k <= 3; k++) begin
         go(); sw = (k < 3);
         @(negedge clk);
         chk($sformatf("L sw grant %0d", k), {30'b0, bus.grant}, 2);
         chk($sformatf("L sw wdata %0d", k), bus.s_wr_data, 32'h12345678);
         chk($sformatf("L sw strobe %0d", k), {28'b0, bus.s_wr_strobe}, 32'hF);
         chk($sformatf("L sw busy %0d", k), {31'b0, bus.busy}, 1);
         chk($sformatf("L sw m0_wait %0d", k), {31'b0, bus.m0_wait}, 1);
      end
      go(); wr[1] = 1'b0; ad[1] = '0; wd[1] = '0; st[1] = '0; sw = 1'b0;
      @(negedge clk);
      chk("L after sw grant", {30'b0, bus.grant}, 1);
      chk("L after sw s_addr", bus.s_addr, 32'h300);
      chk("L after sw busy", {31'b0, bus.busy}, 0);

      // Error with wait: error wins, completes immediately, port 0 becomes last.
      go(); idle_in();
      rd[0] = 1'b1; ad[0] = 32'h400; sw = 1'b1; se = 1'b1;
      @(negedge clk);
      chk("L err m0_err", {31'b0, bus.m0_err}, 1);
      chk("L err m0_wait", {31'b0, bus.m0_wait}, 0);
      go(); idle_in(); rd[0] = 1'b1; rd[1] = 1'b1;
      @(negedge clk);
      chk("L err busy", {31'b0, bus.busy}, 0);
      chk("L err next grant", {30'b0, bus.grant}, 2);

      // Reset mid-HOLD0 drops the enables at once.
      go(); idle_in(); rd[0] = 1'b1; ad[0] = 32'h500; sw = 1'b1;
      @(negedge clk);
      chk("L hold0 grant", {30'b0, bus.grant}, 1);
      go();
      @(negedge clk);
      chk("L hold0 busy", {31'b0, bus.busy}, 1);
      go(); rst = 1'b1; #1;
      chk("L async s_rd_en", {31'b0, bus.s_rd_en}, 0);
      chk("L async busy", {31'b0, bus.busy}, 0);
      go(); rst = 1'b0; idle_in(); rd[0] = 1'b1; rd[1] = 1'b1;
      @(negedge clk);
      chk("L post-rst grant", {30'b0, bus.grant}, 1);

      // Withdrawn request in HOLD0: bus released, no error, bubble cycle.
      go(); idle_in(); rd[0] = 1'b1; ad[0] = 32'h580; sw = 1'b1;
      @(negedge clk);
      chk("L wd grant0", {30'b0, bus.grant}, 1);
      go(); rd[0] = 1'b0; ad[0] = '0; rd[1] = 1'b1; ad[1] = 32'h600;
      @(negedge clk);
      chk("L wd grant", {30'b0, bus.grant}, 0);
      chk("L wd s_rd_en", {31'b0, bus.s_rd_en}, 0);
      chk("L wd m1_wait", {31'b0, bus.m1_wait}, 1);
      chk("L wd m0_err", {31'b0, bus.m0_err}, 0);
      go();
      @(negedge clk);
      chk("L wd m1 grant", {30'b0, bus.grant}, 2);
      chk("L wd m1 addr", bus.s_addr, 32'h600);
      go(); sw = 1'b0;
      @(negedge clk);
      chk("L wd m1 done", {31'b0, bus.m1_wait}, 0);

`ifdef DBUS_ARB_TIMEOUT_EN
      // Stuck slave: forced abort on the fifth request cycle.
      go(); idle_in(); rd[0] = 1'b1; ad[0] = 32'h700; sw = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) go();
         @(negedge clk);
         chk($sformatf("L to m0_err %0d", k), {31'b0, bus.m0_err}, (k == 5) ? 1 : 0);
         chk($sformatf("L to s_rd_en %0d", k), {31'b0, bus.s_rd_en}, (k == 5) ? 0 : 1);
         chk($sformatf("L to m0_wait %0d", k), {31'b0, bus.m0_wait}, (k == 5) ? 0 : 1);
      end
      go(); idle_in();
      @(negedge clk);
      chk("L to busy after", {31'b0, bus.busy}, 0);
`endif

      go(); idle_in();
      go();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single core data bus (DBus) between two requesters: port 0 is the LSU load/store path, port 1 is a secondary master (debug module / DMA).
- Uses the DBus semantics the LSU already drives: rd_en/wr_en with a byte address, write data and strobes, and slave-side wait/err.
- Grants the bus with zero added latency, so an uncontended LSU access still completes in one cycle.
- Round-robin between the ports, and locks the grant while the slave stretches a transaction with wait.

Parameters:
- TIMEOUT_CYCLES, 16, max consecutive slave wait cycles before forced abort (used only with the optional feature); must be ≥2.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- m0_rd_en, m1_rd_en  input  1 each  read request
- m0_wr_en, m1_wr_en  input  1 each  write request
- m0_addr, m1_addr  input  32 each  byte address
- m0_wr_data, m1_wr_data  input  32 each  write data
- m0_wr_strobe, m1_wr_strobe  input  4 each  byte lane strobes
- m0_rd_data, m1_rd_data  output  32 each  read data
- m0_wait, m1_wait  output  1 each  port must hold its request another cycle
- m0_err, m1_err  output  1 each  port's transaction aborted
- s_rd_en, s_wr_en  output  1 each  slave read / write enable
- s_addr  output  32  slave address
- s_wr_data  output  32  slave write data
- s_wr_strobe  output  4  slave write strobes
- s_rd_data  input  32  slave read data
- s_wait  input  1  slave needs more cycles
- s_err  input  1  slave error
- grant  output  2  one-hot current owner, 00 when idle
- busy  output  1  high in any HOLD state

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. Both are fixed.
- Request definition: reqX = mX_rd_en | mX_wr_en. A port never asserts both enables at once. If it does, the arbiter still passes both through unchanged.
- Registered state:
  - state ∈ {IDLE, HOLD0, HOLD1}
  - last: 1 bit, the port that most recently completed
  - wcnt: wait-cycle counter, width $clog2(TIMEOUT_CYCLES+1)
- Reset values: state=IDLE, last=1 (port 0 wins the first tie), wcnt=0.
- While rst is high: s_rd_en=s_wr_en=0, s_wr_strobe=0, grant=00, busy=0, m0_wait=m1_wait=1, m0_err=m1_err=0.
- Winner selection in IDLE (combinational, same cycle):
  - Only one port requests: that port wins.
  - Both request: the port ≠ last wins.
- Slave drive: all s_* request signals come from the winner or owner.
  - No owner: s_* = 0.
  - Read data: both mX_rd_data = s_rd_data; only the owner may sample it.
- Owner response: mX_wait = s_wait & ~s_err; mX_err = s_err.
- Non-owner response: a requesting non-owner sees mX_wait=1, mX_err=0. A non-requesting port sees wait=0, err=0.
- IDLE transitions:
  - Winner with s_wait=0 or s_err=1: completes this cycle. last←winner, stay IDLE.
  - Winner with s_wait=1 and s_err=0: go to HOLDwinner, wcnt←1.
- HOLDx:
  - Owner is x regardless of the other port's request.
  - Completion when s_wait=0 or s_err=1: last←x, wcnt←0, go to IDLE.
  - Otherwise wcnt increments, saturating.
  - The other port's request is evaluated next cycle in IDLE. One idle-cycle bubble is accepted.
- Master withdraws its request in HOLDx (reqx=0, protocol violation): s_* go to 0 that cycle, state←IDLE, last is not updated, no err reported.
- Simultaneous s_err and s_wait: err wins; the transaction is aborted and completes.
- Asynchronous reset mid-HOLD: drops the transaction immediately. The slave sees its enables fall without completion. The slave must tolerate this.
- grant: one-hot of the owner or IDLE winner. busy = (state≠IDLE).

Optional Feature:
- Macro: DBUS_ARB_TIMEOUT_EN.
- When defined, in HOLDx with wcnt==TIMEOUT_CYCLES and s_wait still 1, the arbiter:
  - forces mx_err=1 and mx_wait=0 for that cycle,
  - deasserts s_rd_en/s_wr_en,
  - returns to IDLE with last←x.
- The slave sees its enables drop, which it treats as an abort.
- When undefined: no timeout. wcnt is not instantiated and TIMEOUT_CYCLES is ignored. HOLD lasts until the slave completes.

Test Plan:
- Reset release, m0 LW at addr 0x100, s_wait=0, s_rd_data=0xDEADBEEF → same cycle: s_rd_en=1, s_addr=0x100, m0_rd_data=0xDEADBEEF, m0_wait=0, grant=01, state stays IDLE.
- m0 and m1 both request every cycle, s_wait=0 → grants alternate 01,10,01,10…; the first grant after reset is port 0.
- m1 SW addr 0x200, data 0x12345678, strobe 0xF, s_wait=1 for 3 cycles:
  - s_* held from m1 for 4 cycles; busy=1 in the last 3.
  - m0 requesting concurrently sees m0_wait=1 throughout.
  - m0 is granted on the cycle after completion.
- m0 load with s_err=1 and s_wait=1 in the first cycle → m0_err=1, m0_wait=0, state IDLE, last=0.
- rst pulsed during HOLD0 → s_rd_en/s_wr_en drop asynchronously, state=IDLE; next both-request cycle grants port 0.
- With DBUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, s_wait stuck at 1 on an m0 read → m0_err=1 on the fifth request cycle, s_rd_en=0 that cycle, then IDLE.
